wt_dcache_rrip_repl: RTL and testbench

- Parametrised RRIP replacement-state block for the write-through L1 dcache.
- Holds one RRPV (re-reference prediction value) per set/way and updates it on hits and on miss refills.
- Returns a registered victim way for each refill request.
- Supports SRRIP, BRRIP and SHiP-predicted insertion at run time, plus a configurable hit-promotion policy. Invalid ways are always preferred as victims.

---
 rtl/wt_dcache_rrip_repl.sv | 170 +++++++++++++++++
 tb/tb_wt_dcache_rrip_repl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_rrip_repl.sv
// wt_dcache_rrip_repl: RRIP replacement state for the write-through L1 dcache.
// Holds one RRPV per set/way and updates it on hits and refills. A refill
// request returns its victim way one cycle later. Invalid ways always win.
module wt_dcache_rrip_repl #(
   parameter int unsigned NUM_SETS    = 256,
   parameter int unsigned NUM_WAYS    = 4,
   parameter int unsigned RRPV_W      = 2,
   parameter int unsigned PRED_W      = 2,
   parameter int unsigned BIP_LOG2    = 5,
   parameter int unsigned HIT_PROMOTE = 0,
   localparam int unsigned IDX_W      = $clog2(NUM_SETS),
   localparam int unsigned WAY_W      = $clog2(NUM_WAYS)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic [1:0]          mode_i,
   input  logic                hit_i,
   input  logic [IDX_W-1:0]    hit_idx_i,
   input  logic [WAY_W-1:0]    hit_way_i,
   input  logic                miss_i,
   input  logic [IDX_W-1:0]    miss_idx_i,
   input  logic [NUM_WAYS-1:0] valid_mask_i,
   input  logic [PRED_W-1:0]   pred_i,
   output logic [WAY_W-1:0]    victim_way_o,
   output logic                victim_valid_o,
   output logic                hit_drop_o
);

   localparam logic [RRPV_W-1:0] RRPV_MAX  = '1;
   localparam logic [RRPV_W-1:0] RRPV_LONG = RRPV_MAX - RRPV_W'(1);
   localparam logic [1:0]        MODE_BRRIP = 2'd1;
   localparam logic [1:0]        MODE_SHIP  = 2'd2;

   // Replacement state and registered outputs
   logic [RRPV_W-1:0]   rrpv_q [NUM_SETS][NUM_WAYS];
   logic [BIP_LOG2-1:0] bip_cnt_q;
   logic [WAY_W-1:0]    victim_way_q;
   logic                victim_valid_q;
   logic                hit_drop_q;

   // Refill path
   logic [RRPV_W-1:0]   set_rrpv   [NUM_WAYS];
   logic [RRPV_W-1:0]   set_rrpv_d [NUM_WAYS];
   logic [RRPV_W-1:0]   set_max;
   logic [RRPV_W-1:0]   age_amt;
   logic [RRPV_W-1:0]   ins_rrpv;
   logic                any_invalid;
   logic [WAY_W-1:0]    inv_way;
   logic [WAY_W-1:0]    max_way;
   logic [WAY_W-1:0]    victim_way_d;

   // Hit path
   logic                hit_way_ok;
   logic                hit_conflict;
   logic                hit_apply;
   logic [RRPV_W-1:0]   hit_cur;
   logic [RRPV_W-1:0]   hit_new;

   // Hit way range check only matters when NUM_WAYS is not a power of two
   if (NUM_WAYS == (2 ** WAY_W)) begin : g_way_pow2
      assign hit_way_ok = 1'b1;
   end else begin : g_way_npow2
      assign hit_way_ok = (hit_way_i < WAY_W'(NUM_WAYS));
   end

   // A hit in the same set as a refill loses to the refill
   assign hit_conflict = hit_i & miss_i & (hit_idx_i == miss_idx_i);
   assign hit_apply    = hit_i & hit_way_ok & ~hit_conflict;
   assign hit_cur      = rrpv_q[hit_idx_i][hit_way_i];

   // Hit promotion: hit-priority clears, frequency-priority steps down to 0
   always_comb begin
      hit_new = '0;
      if ((HIT_PROMOTE != 0) && (hit_cur != '0)) begin
         hit_new = hit_cur - RRPV_W'(1);
      end
   end

   // Maximum RRPV currently held in the refill set
   always_comb begin
      set_max = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (set_rrpv[w] > set_max) set_max = set_rrpv[w];
      end
   end

   // Lowest-index invalid way and lowest-index way at the set maximum
   always_comb begin
      any_invalid = 1'b0;
      inv_way     = '0;
      max_way     = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_mask_i[w]) begin
            any_invalid = 1'b1;
            inv_way     = WAY_W'(w);
         end
         if (set_rrpv[w] == set_max) max_way = WAY_W'(w);
      end
   end

   // Insertion RRPV for the incoming line; reserved mode behaves as SRRIP
   always_comb begin
      ins_rrpv = RRPV_LONG;
      case (mode_i)
         MODE_BRRIP: ins_rrpv = (bip_cnt_q == '0) ? RRPV_LONG : RRPV_MAX;
         MODE_SHIP: begin
            if (pred_i == '0)  ins_rrpv = RRPV_MAX;
            else if (&pred_i)  ins_rrpv = '0;
         end
         default: ins_rrpv = RRPV_LONG;
      endcase
   end

   // Aging lifts the set so its maximum lands on RRPV_MAX; skipped if a way is free
   assign victim_way_d = any_invalid ? inv_way : max_way;
   assign age_amt      = any_invalid ? '0 : (RRPV_MAX - set_max);

   for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      assign set_rrpv[gi]   = rrpv_q[miss_idx_i][gi];
      assign set_rrpv_d[gi] = (victim_way_d == WAY_W'(gi)) ? ins_rrpv
                                                           : (set_rrpv[gi] + age_amt);
   end

   // RRPV array: reset/flush to RRPV_MAX, else refill set and independent hit
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++)
               rrpv_q[s][w] <= RRPV_MAX;
      end else if (flush_i) begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++)
               rrpv_q[s][w] <= RRPV_MAX;
      end else begin
         if (hit_apply) rrpv_q[hit_idx_i][hit_way_i] <= hit_new;
         if (miss_i) begin
            for (int w = 0; w < NUM_WAYS; w++)
               rrpv_q[miss_idx_i][w] <= set_rrpv_d[w];
         end
      end
   end

   // Victim/drop pulses and BRRIP throttle counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bip_cnt_q      <= '0;
         victim_way_q   <= '0;
         victim_valid_q <= 1'b0;
         hit_drop_q     <= 1'b0;
      end else if (flush_i) begin
         bip_cnt_q      <= '0;
         victim_way_q   <= '0;
         victim_valid_q <= 1'b0;
         hit_drop_q     <= 1'b0;
      end else begin
         victim_valid_q <= miss_i;
         hit_drop_q     <= hit_conflict;
         if (miss_i) begin
            victim_way_q <= victim_way_d;
            if (mode_i == MODE_BRRIP) bip_cnt_q <= bip_cnt_q + BIP_LOG2'(1);
         end
      end
   end

   assign victim_way_o   = victim_way_q;
   assign victim_valid_o = victim_valid_q;
   assign hit_drop_o     = hit_drop_q;

endmodule

// File: tb/tb_wt_dcache_rrip_repl.sv
// Testbench for wt_dcache_rrip_repl: table-driven refill vectors plus
// hand-written hit/conflict/flush sequences, with a victim-way scoreboard.
// Two instances share refill stimulus: dut_a hit-priority, dut_b frequency-priority.
module tb_wt_dcache_rrip_repl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       miss = 1'b0;
   logic [7:0] miss_idx = 8'd0;
   logic [3:0] vmask = 4'd0;
   logic [1:0] pred = 2'd0;
   logic       hit_a = 1'b0;
   logic [7:0] hidx_a = 8'd0;
   logic [1:0] hway_a = 2'd0;
   logic       hit_b = 1'b0;
   logic [7:0] hidx_b = 8'd0;
   logic [1:0] hway_b = 2'd0;
   logic [1:0] vway_a, vway_b;
   logic       vvalid_a, vvalid_b, drop_a, drop_b;

   int n_vec = 0;
   int n_err = 0;
   int sb_q[$];

   always #5 clk = ~clk;

   wt_dcache_rrip_repl #(.NUM_SETS(256), .NUM_WAYS(4), .RRPV_W(2), .PRED_W(2),
                         .BIP_LOG2(5), .HIT_PROMOTE(0)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mode_i(mode),
      .hit_i(hit_a), .hit_idx_i(hidx_a), .hit_way_i(hway_a),
      .miss_i(miss), .miss_idx_i(miss_idx), .valid_mask_i(vmask), .pred_i(pred),
      .victim_way_o(vway_a), .victim_valid_o(vvalid_a), .hit_drop_o(drop_a));

   wt_dcache_rrip_repl #(.NUM_SETS(256), .NUM_WAYS(4), .RRPV_W(2), .PRED_W(2),
                         .BIP_LOG2(5), .HIT_PROMOTE(1)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mode_i(mode),
      .hit_i(hit_b), .hit_idx_i(hidx_b), .hit_way_i(hway_b),
      .miss_i(miss), .miss_idx_i(miss_idx), .valid_mask_i(vmask), .pred_i(pred),
      .victim_way_o(vway_b), .victim_valid_o(vvalid_b), .hit_drop_o(drop_b));

   typedef struct {
      int         idx;
      logic [3:0] mask;
      logic [1:0] md;
      logic [1:0] p;
      int         exp_way;
      int         exp_ins;
   } vec_t;

   vec_t vt [14];

   function automatic int rr_a(input int s, input int w);
      return int'(dut_a.rrpv_q[s][w]);
   endfunction

   function automatic int rr_b(input int s, input int w);
      return int'(dut_b.rrpv_q[s][w]);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive_miss(input int idx, input logic [3:0] m, input logic [1:0] md,
                             input logic [1:0] p, input int exp_way);
      miss     = 1'b1;
      miss_idx = 8'(idx);
      vmask    = m;
      mode     = md;
      pred     = p;
      if (!flush) sb_q.push_back(exp_way);
   endtask

   // One clock: sample #1 after the edge, pop the scoreboard on a victim pulse
   task automatic tick(input string nm, input bit exp_valid, input bit exp_drop);
      int exp_way;
      @(posedge clk);
      #1;
      chk({nm, " valid_a"}, int'(vvalid_a), int'(exp_valid));
      chk({nm, " valid_b"}, int'(vvalid_b), int'(exp_valid));
      chk({nm, " drop_a"}, int'(drop_a), int'(exp_drop));
      if (vvalid_a) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s way: got %0d with no request outstanding", nm, vway_a);
         end else begin
            exp_way = sb_q.pop_front();
            chk({nm, " way_a"}, int'(vway_a), exp_way);
            chk({nm, " way_b"}, int'(vway_b), exp_way);
         end
      end
      $display("txn %s: valid=%0d way=%0d drop=%0d", nm, vvalid_a, vway_a, drop_a);
      miss  = 1'b0;
      hit_a = 1'b0;
      hit_b = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // idx, mask, mode, pred, victim, inserted RRPV
      vt[0]  = '{5,  4'b0000, 2'd0, 2'd0, 0, 2};
      vt[1]  = '{5,  4'b0001, 2'd0, 2'd0, 1, 2};
      vt[2]  = '{5,  4'b1111, 2'd0, 2'd0, 2, 2};
      vt[3]  = '{5,  4'b1111, 2'd0, 2'd0, 3, 2};
      vt[4]  = '{5,  4'b1111, 2'd0, 2'd0, 0, 2};
      vt[5]  = '{6,  4'b1111, 2'd3, 2'd0, 0, 2};
      vt[6]  = '{6,  4'b1011, 2'd2, 2'd3, 2, 0};
      vt[7]  = '{6,  4'b1111, 2'd2, 2'd0, 1, 3};
      vt[8]  = '{6,  4'b1111, 2'd2, 2'd1, 1, 2};
      vt[9]  = '{6,  4'b1111, 2'd0, 2'd0, 3, 2};
      vt[10] = '{6,  4'b1111, 2'd0, 2'd0, 0, 2};
      vt[11] = '{10, 4'b1111, 2'd2, 2'd0, 0, 3};
      vt[12] = '{11, 4'b1111, 2'd2, 2'd3, 0, 0};
      vt[13] = '{12, 4'b1111, 2'd2, 2'd1, 0, 2};

      // Reset state
      #12;
      chk("reset valid", int'(vvalid_a), 0);
      chk("reset way", int'(vway_a), 0);
      chk("reset drop", int'(drop_a), 0);
      for (int w = 0; w < 4; w++) chk($sformatf("reset rrpv[5][%0d]", w), rr_a(5, w), 3);
      chk("reset rrpv_b[3][2]", rr_b(3, 2), 3);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table: back-to-back refills
      for (int i = 0; i < 14; i++) begin
         drive_miss(vt[i].idx, vt[i].mask, vt[i].md, vt[i].p, vt[i].exp_way);
         tick($sformatf("vec%0d", i), 1'b1, 1'b0);
         chk($sformatf("vec%0d ins", i), rr_a(vt[i].idx, vt[i].exp_way), vt[i].exp_ins);
      end
      begin
         int exp5 [4] = '{2, 3, 3, 3};
         int exp6 [4] = '{2, 3, 1, 3};
         for (int w = 0; w < 4; w++) begin
            chk($sformatf("set5 way%0d", w), rr_a(5, w), exp5[w]);
            chk($sformatf("set6 way%0d", w), rr_a(6, w), exp6[w]);
         end
      end

      // Set 7: build {0,1,0,1} in dut_b, then one all-valid SRRIP refill
      drive_miss(7, 4'b0000, 2'd2, 2'd3, 0); tick("s7 fill0", 1'b1, 1'b0);
      drive_miss(7, 4'b0001, 2'd0, 2'd0, 1); tick("s7 fill1", 1'b1, 1'b0);
      drive_miss(7, 4'b0011, 2'd2, 2'd3, 2); tick("s7 fill2", 1'b1, 1'b0);
      drive_miss(7, 4'b0111, 2'd0, 2'd0, 3); tick("s7 fill3", 1'b1, 1'b0);
      hit_b = 1'b1; hidx_b = 8'd7; hway_b = 2'd1; tick("s7 hit1", 1'b0, 1'b0);
      hit_b = 1'b1; hidx_b = 8'd7; hway_b = 2'd3; tick("s7 hit3", 1'b0, 1'b0);
      begin
         int pre_b [4] = '{0, 1, 0, 1};
         int fin_b [4] = '{2, 2, 2, 3};
         int fin_a [4] = '{1, 2, 1, 3};
         for (int w = 0; w < 4; w++) chk($sformatf("s7 pre_b way%0d", w), rr_b(7, w), pre_b[w]);
         drive_miss(7, 4'b1111, 2'd0, 2'd0, 1);
         tick("s7 age", 1'b1, 1'b0);
         for (int w = 0; w < 4; w++) begin
            chk($sformatf("s7 fin_b way%0d", w), rr_b(7, w), fin_b[w]);
            chk($sformatf("s7 fin_a way%0d", w), rr_a(7, w), fin_a[w]);
         end
      end

      // BRRIP: 33 insertions, first and 33rd near, the rest distant
      for (int i = 0; i < 33; i++) begin
         drive_miss(20 + i, 4'b1111, 2'd1, 2'd0, 0);
         tick($sformatf("brrip%0d", i + 1), 1'b1, 1'b0);
         chk($sformatf("brrip%0d ins", i + 1), rr_a(20 + i, 0), (i == 0 || i == 32) ? 2 : 3);
      end

      // Hit promotion on set 3 way 2
      hit_a = 1'b1; hidx_a = 8'd3; hway_a = 2'd2;
      hit_b = 1'b1; hidx_b = 8'd3; hway_b = 2'd2;
      tick("hit1", 1'b0, 1'b0);
      chk("hit1 a", rr_a(3, 2), 0);
      chk("hit1 b", rr_b(3, 2), 2);
      hit_b = 1'b1; hidx_b = 8'd3; hway_b = 2'd2;
      tick("hit2", 1'b0, 1'b0);
      chk("hit2 b", rr_b(3, 2), 1);
      hit_b = 1'b1; tick("hit3", 1'b0, 1'b0);
      hit_b = 1'b1; tick("hit4", 1'b0, 1'b0);
      chk("hit4 b sat", rr_b(3, 2), 0);
      chk("hit4 b neighbour", rr_b(3, 1), 3);

      // Same-set conflict: refill wins, drop pulses
      drive_miss(9, 4'b1111, 2'd0, 2'd0, 0);
      hit_a = 1'b1; hidx_a = 8'd9; hway_a = 2'd0;
      tick("conflict", 1'b1, 1'b1);
      chk("conflict rrpv", rr_a(9, 0), 2);
      // Different sets same cycle: both apply
      drive_miss(13, 4'b1111, 2'd0, 2'd0, 0);
      hit_a = 1'b1; hidx_a = 8'd14; hway_a = 2'd1;
      tick("dual", 1'b1, 1'b0);
      chk("dual miss", rr_a(13, 0), 2);
      chk("dual hit", rr_a(14, 1), 0);

      // Flush beats miss and hit in the same cycle
      flush = 1'b1;
      drive_miss(15, 4'b0000, 2'd0, 2'd0, 0);
      hit_a = 1'b1; hidx_a = 8'd15; hway_a = 2'd1;
      tick("flush", 1'b0, 1'b0);
      chk("flush rrpv[5][0]", rr_a(5, 0), 3);
      chk("flush rrpv[6][2]", rr_a(6, 2), 3);
      chk("flush rrpv[15][0]", rr_a(15, 0), 3);
      chk("flush rrpv[15][1]", rr_a(15, 1), 3);
      chk("flush rrpv[3][2]", rr_a(3, 2), 3);
      chk("flush rrpv_b[7][0]", rr_b(7, 0), 3);
      chk("flush rrpv_b[3][2]", rr_b(3, 2), 3);
      tick("idle", 1'b0, 1'b0);

      // BRRIP counter was cleared by the flush
      drive_miss(30, 4'b1111, 2'd1, 2'd0, 0);
      tick("post-flush brrip1", 1'b1, 1'b0);
      chk("post-flush brrip1 ins", rr_a(30, 0), 2);
      drive_miss(31, 4'b1111, 2'd1, 2'd0, 0);
      tick("post-flush brrip2", 1'b1, 1'b0);
      chk("post-flush brrip2 ins", rr_a(31, 0), 3);

      tick("drain", 1'b0, 1'b0);
      chk("scoreboard drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
